// File: rtl/dc_decimator.sv
// dc_decimator
//   Decimating averager for the DC-removal filter output. Sums 2^DEC_LOG2
//   consecutive Q9.23 samples (one per enable_3M strobe). Divides the sum by
//   the sample count with an arithmetic shift and saturates the result to a
//   Q9.7 16-bit word. Each result is pushed into a 2-entry FIFO, which is read
//   by the consumer through a valid/ready handshake.
//
//   Build option: define DC_DECIM_ROUND_EN to round half-up before the
//   shift. Without it the shift truncates toward minus infinity. Saturation
//   is present in both builds.
//
//   Ports
//     CLK_24M    in   system clock, rising edge
//     reset      in   asynchronous reset, active low
//     enable_3M  in   one-cycle sample strobe
//     filter_in  in   [31:0] signed Q9.23 sample, valid when enable_3M=1
//     sync       in   synchronous frame restart (drops the partial sum)
//     out_data   out  [15:0] signed Q9.7 result at the FIFO head
//     out_valid  out  FIFO non-empty
//     out_ready  in   consumer takes out_data this cycle
//     overrun    out  sticky, set when a result is dropped on a full FIFO
//     ovr_clr    in   synchronous clear of overrun (a new drop wins)
module dc_decimator #(
  parameter int DEC_LOG2 = 3
) (
  input  logic               CLK_24M,
  input  logic               reset,
  input  logic               enable_3M,
  input  logic signed [31:0] filter_in,
  input  logic               sync,
  output logic signed [15:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun,
  input  logic               ovr_clr
);

  localparam int DATA_W = 32;
  localparam int OUT_W  = 16;
  localparam int ACC_W  = DATA_W + DEC_LOG2 + 1;
  localparam int SHIFT  = DEC_LOG2 + 16;
  localparam int QUO_W  = ACC_W - SHIFT;
  localparam logic [DEC_LOG2-1:0] CNT_LAST = '1;
`ifdef DC_DECIM_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (SHIFT - 1);
`endif

  // The upper bits of the sum are the floor of the division. This is the
  // same result as an arithmetic right shift by SHIFT.
  function automatic logic signed [QUO_W-1:0] round_shift(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] r;
`ifdef DC_DECIM_ROUND_EN
    r = s + RND_BIAS;
`else
    r = s;
`endif
    return r[ACC_W-1:SHIFT];
  endfunction

  // The quotient has one bit more than the output word. If its top two bits
  // differ, the value is outside the Q9.7 range.
  function automatic logic signed [OUT_W-1:0] sat_q97(input logic signed [QUO_W-1:0] q);
    if (q[QUO_W-1] != q[OUT_W-1])
      return q[QUO_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return q[OUT_W-1:0];
  endfunction

  logic signed [ACC_W-1:0]  acc_p0;
  logic [DEC_LOG2-1:0]      cnt_p0;
  logic signed [ACC_W-1:0]  in_ext_p0;
  logic signed [ACC_W-1:0]  sum_p0;
  logic signed [OUT_W-1:0]  res_p0;
  logic                     vld_p0;

  logic signed [OUT_W-1:0]  fifo0_p1;
  logic signed [OUT_W-1:0]  fifo1_p1;
  logic [1:0]               count_p1;
  logic                     pop;
  logic                     push;
  logic                     drop;

  // ---- stage p0: accumulate, dump, convert ----
  always_comb begin
    in_ext_p0 = {{(ACC_W-DATA_W){filter_in[DATA_W-1]}}, filter_in};
    sum_p0    = acc_p0 + in_ext_p0;
    vld_p0    = enable_3M && !sync && (cnt_p0 == CNT_LAST);
    res_p0    = sat_q97(round_shift(sum_p0));
  end

  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (sync) begin
      // A strobe that arrives with sync is the first sample of the new frame.
      acc_p0 <= enable_3M ? in_ext_p0 : '0;
      cnt_p0 <= enable_3M ? DEC_LOG2'(1) : '0;
    end else if (enable_3M) begin
      if (cnt_p0 == CNT_LAST) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end else begin
        acc_p0 <= sum_p0;
        cnt_p0 <= cnt_p0 + DEC_LOG2'(1);
      end
    end
  end

  // ---- stage p1: 2-entry output FIFO (entry 0 is the head) ----
  always_comb begin
    out_valid = (count_p1 != 2'd0);
    out_data  = fifo0_p1;
    pop       = out_valid && out_ready;
    push      = vld_p0 && ((count_p1 != 2'd2) || pop);
    drop      = vld_p0 && (count_p1 == 2'd2) && !pop;
  end

  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      count_p1 <= 2'd0;
      fifo0_p1 <= '0;
      fifo1_p1 <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_p1 == 2'd0) fifo0_p1 <= res_p0;
          else                  fifo1_p1 <= res_p0;
          count_p1 <= count_p1 + 2'd1;
        end
        2'b01: begin
          fifo0_p1 <= fifo1_p1;
          count_p1 <= count_p1 - 2'd1;
        end
        2'b11: begin
          if (count_p1 == 2'd1) begin
            fifo0_p1 <= res_p0;
          end else begin
            fifo0_p1 <= fifo1_p1;
            fifo1_p1 <= res_p0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset)       overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_dc_decimator.sv
module tb_dc_decimator;

  logic               CLK_24M   = 1'b0;
  logic               reset     = 1'b0;
  logic               enable_3M = 1'b0;
  logic signed [31:0] filter_in = '0;
  logic               sync      = 1'b0;
  logic               out_ready = 1'b0;
  logic               ovr_clr   = 1'b0;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               overrun;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DC_DECIM_ROUND_EN
  localparam logic [15:0] EXP_POS_HALF = 16'h0001;
  localparam logic [15:0] EXP_NEG_HALF = 16'h0000;
`else
  localparam logic [15:0] EXP_POS_HALF = 16'h0000;
  localparam logic [15:0] EXP_NEG_HALF = 16'hFFFF;
`endif

  localparam logic [31:0] ONE   = 32'h0080_0000;
  localparam logic [31:0] TWO   = 32'h0100_0000;
  localparam logic [31:0] THREE = 32'h0180_0000;

  always #5 CLK_24M = ~CLK_24M;

  dc_decimator #(.DEC_LOG2(3)) dut (
    .CLK_24M   (CLK_24M),
    .reset     (reset),
    .enable_3M (enable_3M),
    .filter_in (filter_in),
    .sync      (sync),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  // One strobe: driven at the falling edge, returns 1 time unit after the
  // rising edge that samples it.
  task automatic strobe(input logic [31:0] d);
    @(negedge CLK_24M);
    enable_3M = 1'b1;
    filter_in = d;
    @(posedge CLK_24M);
    #1;
    enable_3M = 1'b0;
  endtask

  task automatic strobes(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) strobe(d);
  endtask

  task automatic test_reset;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", out_data); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_unity;
    out_ready = 1'b1;
    strobes(ONE, 7);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unity_early: got valid %b want 0", out_valid); end
    strobe(ONE);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL unity_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 16'h0080) begin n_fail++; $display("FAIL unity_data: got %h want 0080", out_data); end
    @(posedge CLK_24M); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unity_one_cycle: got valid %b want 0", out_valid); end
    strobes(ONE, 8);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0080) begin n_fail++; $display("FAIL unity_frame2: got valid %b data %h want 1 0080", out_valid, out_data); end
  endtask

  task automatic test_rounding;
    strobes(32'h0000_8000, 8);
    n_checks++; if (out_valid !== 1'b1 || out_data !== EXP_POS_HALF) begin n_fail++; $display("FAIL round_pos: got valid %b data %h want 1 %h", out_valid, out_data, EXP_POS_HALF); end
    strobes(32'hFFFF_8000, 8);
    n_checks++; if (out_valid !== 1'b1 || out_data !== EXP_NEG_HALF) begin n_fail++; $display("FAIL round_neg: got valid %b data %h want 1 %h", out_valid, out_data, EXP_NEG_HALF); end
  endtask

  task automatic test_saturation;
    strobes(32'h7FFF_FFFF, 8);
    n_checks++; if (out_data !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos: got %h want 7fff", out_data); end
    strobes(32'h8000_0000, 8);
    n_checks++; if (out_data !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %h want 8000", out_data); end
    for (int i = 0; i < 4; i++) begin
      strobe(32'h7FFF_FFFF);
      strobe(32'h8000_0001);
    end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0000) begin n_fail++; $display("FAIL sat_alt: got valid %b data %h want 1 0000", out_valid, out_data); end
  endtask

  task automatic test_backpressure;
    @(posedge CLK_24M); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got valid %b want 0", out_valid); end
    strobes(ONE, 8);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0080) begin n_fail++; $display("FAIL bp_first: got valid %b data %h want 1 0080", out_valid, out_data); end
    strobes(TWO, 8);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_no_ovr_yet: got %b want 0", overrun); end
    strobes(THREE, 8);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun: got %b want 1", overrun); end
    n_checks++; if (out_data !== 16'h0080) begin n_fail++; $display("FAIL bp_head_stable: got %h want 0080", out_data); end
    @(negedge CLK_24M);
    out_ready = 1'b1;
    n_checks++; if (out_data !== 16'h0080) begin n_fail++; $display("FAIL bp_pop1: got %h want 0080", out_data); end
    @(posedge CLK_24M); #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0100) begin n_fail++; $display("FAIL bp_pop2: got valid %b data %h want 1 0100", out_valid, out_data); end
    @(posedge CLK_24M); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got valid %b want 0", out_valid); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_sticky: got %b want 1", overrun); end
    @(negedge CLK_24M);
    ovr_clr = 1'b1;
    @(posedge CLK_24M); #1;
    ovr_clr = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_ovr_clr: got %b want 0", overrun); end
  endtask

  task automatic test_sync;
    out_ready = 1'b1;
    strobes(TWO, 5);
    @(negedge CLK_24M);
    sync = 1'b1;
    @(posedge CLK_24M); #1;
    sync = 1'b0;
    strobes(TWO, 7);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sync_no_dump: got valid %b want 0", out_valid); end
    strobe(TWO);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0100) begin n_fail++; $display("FAIL sync_dump: got valid %b data %h want 1 0100", out_valid, out_data); end
    @(posedge CLK_24M); #1;
    @(negedge CLK_24M);
    sync      = 1'b1;
    enable_3M = 1'b1;
    filter_in = ONE;
    @(posedge CLK_24M); #1;
    sync      = 1'b0;
    enable_3M = 1'b0;
    strobes(ONE, 6);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sync_en_early: got valid %b want 0", out_valid); end
    strobe(ONE);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0080) begin n_fail++; $display("FAIL sync_en_dump: got valid %b data %h want 1 0080", out_valid, out_data); end
  endtask

  task automatic test_push_pop_full;
    @(posedge CLK_24M); #1;
    out_ready = 1'b0;
    strobes(ONE, 8);
    strobes(TWO, 8);
    strobes(THREE, 7);
    @(negedge CLK_24M);
    enable_3M = 1'b1;
    filter_in = THREE;
    out_ready = 1'b1;
    @(posedge CLK_24M); #1;
    enable_3M = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL pp_no_overrun: got %b want 0", overrun); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0100) begin n_fail++; $display("FAIL pp_head: got valid %b data %h want 1 0100", out_valid, out_data); end
    @(negedge CLK_24M);
    out_ready = 1'b1;
    @(posedge CLK_24M); #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0180) begin n_fail++; $display("FAIL pp_second: got valid %b data %h want 1 0180", out_valid, out_data); end
    @(posedge CLK_24M); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    strobes(ONE, 8);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got valid %b want 1", out_valid); end
    strobes(TWO, 4);
    @(negedge CLK_24M);
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_async: got valid %b data %h want 0 0000", out_valid, out_data); end
    @(negedge CLK_24M);
    reset = 1'b1;
    strobes(ONE, 7);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_early: got valid %b want 0", out_valid); end
    strobe(ONE);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0080) begin n_fail++; $display("FAIL rst_mid_dump: got valid %b data %h want 1 0080", out_valid, out_data); end
  endtask

  initial begin
    repeat (3) @(posedge CLK_24M);
    #1;
    test_reset;
    @(negedge CLK_24M);
    reset = 1'b1;
    test_unity;
    test_rounding;
    test_saturation;
    test_backpressure;
    test_sync;
    test_push_pop_full;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
